// File: rtl/ex_wb_pkg.sv
// ex_wb_pkg: shared bundles and default widths
// for the execute-to-writeback stage.
package ex_wb_pkg;

  localparam int DATAW_D  = 32;
  localparam int PCW_D    = 32;
  localparam int REGW_D   = 5;
  localparam int SHADOW_D = 2;

  typedef struct packed {
    logic              we;
    logic [REGW_D-1:0] waddr;
    logic [DATAW_D-1:0] wdata;
  } wb_entry_t;

  typedef struct packed {
    logic             valid;
    logic [PCW_D-1:0] pc;
  } redirect_t;

endpackage

// File: rtl/ex_wb_stage_squash_ctrl.sv
// squash_ctrl: counts down the younger instructions
// that must be discarded after a taken branch.
module squash_ctrl #(
  parameter int SHADOW = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic accept,
  output logic kill,
  output logic active
);

  localparam int CW = $clog2(SHADOW + 1);
  localparam logic [CW-1:0] RELOAD = CW'(SHADOW);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt;

  assign active = (cnt != '0);
  assign kill   = accept && active;

  // load on a live taken branch, step down only on killed accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      unique case (1'b1)
        kill:    cnt <= cnt - ONE;
        load:    cnt <= RELOAD;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: registers execute results into the
// rf write port, forwarding bus and fetch redirect.
module ex_wb_stage
  import ex_wb_pkg::*;
#(
  parameter int DATAW  = DATAW_D,
  parameter int PCW    = PCW_D,
  parameter int REGW   = REGW_D,
  parameter int SHADOW = SHADOW_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [DATAW-1:0] ex_out,
  input  logic [PCW-1:0]   pc_target,
  input  logic             branch_taken,
  input  logic             wr_en_in,
  input  logic [REGW-1:0]  rd_in,
  output logic             rf_we,
  output logic [REGW-1:0]  rf_waddr,
  output logic [DATAW-1:0] rf_wdata,
  output logic             fwd_valid,
  output logic [REGW-1:0]  fwd_addr,
  output logic [DATAW-1:0] fwd_data,
  output logic             redirect_valid,
  output logic [PCW-1:0]   redirect_pc,
  output logic             squash_active
);

  logic accept;
  logic kill;
  logic live;
  logic wr_live;
  logic br_live;

  wb_entry_t wb_q;
  redirect_t rd_q;

  assign ex_ready = !stall;
  assign accept   = ex_valid && !stall;
  assign live     = accept && !kill;
  assign wr_live  = live && wr_en_in && (rd_in != '0);
  assign br_live  = live && branch_taken;

  squash_ctrl #(
    .SHADOW(SHADOW)
  ) u_squash (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (br_live),
    .accept(accept),
    .kill  (kill),
    .active(squash_active)
  );

  // writeback entry: pulse we, hold address/data between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else begin
      wb_q.we <= wr_live;
      if (wr_live) begin
        wb_q.waddr <= rd_in;
        wb_q.wdata <= ex_out;
      end
    end
  end

  // redirect: one-cycle pulse, target held afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q.valid <= br_live;
      if (br_live) begin
        rd_q.pc <= pc_target;
      end
    end
  end

  assign rf_we          = wb_q.we;
  assign rf_waddr       = wb_q.waddr;
  assign rf_wdata       = wb_q.wdata;
  assign fwd_valid      = wb_q.we;
  assign fwd_addr       = wb_q.waddr;
  assign fwd_data       = wb_q.wdata;
  assign redirect_valid = rd_q.valid;
  assign redirect_pc    = rd_q.pc;

endmodule
